// File: rtl/mcbsp0_master_tx.sv
// McBSP0 transmit master: serialises 32-bit words MSB-first onto a free-running
// bit clock with a one-bit frame sync, using a one-word holding register.
module mcbsp0_master_tx #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        mcbsp_master_clk,
  input  logic        mcbsp_master_rst,
  input  logic [6:0]  cfg_length,
  input  logic [7:0]  cfg_gap,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        mcbsp_master_clkx,
  output logic        mcbsp_master_fsx,
  output logic        mcbsp_master_mosi,
  output logic        tx_busy,
  output logic        tx_word_done,
  output logic [31:0] debug_signal
);

  localparam logic [8:0] DIV_HALF = 9'(CLK_DIV);
  localparam logic [8:0] DIV_LAST = 9'(2 * CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [8:0]  div_cnt, div_n;
  logic        tick, clkx;
  logic [31:0] hold_data;
  logic        hold_full;
  logic [31:0] sh, sh_n, first_sh;
  logic [5:0]  len, len_n, len_eff;
  logic [5:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  gap_cnt, gap_cnt_n;
  logic        fsx, fsx_n, mosi, mosi_n;
  logic        done, done_n;
  logic        load, idle_eval;

  // Divider: free-running; tick is the last count, so registered fsx/mosi
  // change on the same edge that clkx falls.
  assign tick  = (div_cnt == DIV_LAST);
  assign div_n = tick ? 9'd0 : div_cnt + 9'd1;

  always_ff @(posedge mcbsp_master_clk) begin
    if (mcbsp_master_rst) begin
      div_cnt <= 9'd0;
      clkx    <= 1'b0;
    end else begin
      div_cnt <= div_n;
      clkx    <= (div_n >= DIV_HALF);
    end
  end

  // Holding register; accept and transfer are exclusive since ready = !full.
  assign tx_ready = !hold_full;

  always_ff @(posedge mcbsp_master_clk) begin
    if (mcbsp_master_rst) begin
      hold_full <= 1'b0;
      hold_data <= 32'd0;
    end else if (tx_valid && tx_ready) begin
      hold_full <= 1'b1;
      hold_data <= tx_data;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  // Left-justify the word so the first bit to send is always sh[31].
  assign len_eff  = (cfg_length == 7'd0 || cfg_length > 7'd32) ? 6'd32 : cfg_length[5:0];
  assign first_sh = hold_data << (6'd32 - len_eff);

  always_ff @(posedge mcbsp_master_clk) begin
    if (mcbsp_master_rst) state <= IDLE;
    else                  state <= state_n;
  end

  always_comb begin
    state_n   = state;
    sh_n      = sh;
    len_n     = len;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    fsx_n     = fsx;
    mosi_n    = mosi;
    done_n    = 1'b0;
    load      = 1'b0;
    idle_eval = 1'b0;
    if (tick) begin
      case (state)
        IDLE: idle_eval = 1'b1;
        SHIFT: begin
          if (bit_cnt < len) begin
            fsx_n     = 1'b0;
            mosi_n    = sh[30];
            sh_n      = {sh[30:0], 1'b0};
            bit_cnt_n = bit_cnt + 6'd1;
          end else begin
            done_n = 1'b1;
            if (cfg_gap == 8'd0) begin
              idle_eval = 1'b1;
            end else begin
              gap_cnt_n = cfg_gap;
              fsx_n     = 1'b0;
              mosi_n    = 1'b0;
              state_n   = GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt <= 8'd1) begin
            gap_cnt_n = 8'd0;
            idle_eval = 1'b1;
          end else begin
            gap_cnt_n = gap_cnt - 8'd1;
            fsx_n     = 1'b0;
            mosi_n    = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    // Shared word-start decision: a pending word starts on this very tick.
    if (idle_eval) begin
      if (hold_full) begin
        load      = 1'b1;
        state_n   = SHIFT;
        sh_n      = first_sh;
        len_n     = len_eff;
        bit_cnt_n = 6'd1;
        fsx_n     = 1'b1;
        mosi_n    = first_sh[31];
      end else begin
        state_n = IDLE;
        fsx_n   = 1'b0;
        mosi_n  = 1'b0;
      end
    end
  end

  always_ff @(posedge mcbsp_master_clk) begin
    if (mcbsp_master_rst) begin
      sh      <= 32'd0;
      len     <= 6'd32;
      bit_cnt <= 6'd0;
      gap_cnt <= 8'd0;
      fsx     <= 1'b0;
      mosi    <= 1'b0;
      done    <= 1'b0;
    end else begin
      sh      <= sh_n;
      len     <= len_n;
      bit_cnt <= bit_cnt_n;
      gap_cnt <= gap_cnt_n;
      fsx     <= fsx_n;
      mosi    <= mosi_n;
      done    <= done_n;
    end
  end

  assign mcbsp_master_clkx = clkx;
  assign mcbsp_master_fsx  = fsx;
  assign mcbsp_master_mosi = mosi;
  assign tx_busy           = (state != IDLE);
  assign tx_word_done      = done;

  // Pad narrowed to 2 bits so the full field list fits in 32 bits.
  assign debug_signal = {state, bit_cnt, gap_cnt, div_cnt[7:0],
                         hold_full, clkx, fsx, mosi, 2'b00, tx_busy, done};

endmodule

// File: tb/tb_mcbsp0_master_tx.sv
// Directed bench for mcbsp0_master_tx: a receiver model samples on clkx rise
// and rebuilds words, frame start times and idle-bit runs for checking.
module tb_mcbsp0_master_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  cfg_length = 7'd32;
  logic [7:0]  cfg_gap = 8'd0;
  logic [31:0] tx_data = 32'd0;
  logic        tx_valid = 1'b0;
  logic        tx_ready, clkx, fsx, mosi, tx_busy, tx_word_done;
  logic [31:0] debug_signal;

  int tests = 0, errs = 0, cyc = 0;
  int rx_len = 32, rx_cnt = 0, idle_n = 0, fsx_hi_n = 0, send_wait = 0;
  logic [31:0] rx_sh = 32'd0;
  logic [31:0] rx_q[$];
  int gap_q[$], fsx_q[$], done_q[$], clkr_q[$];
  logic fs_mosi_q[$];
  logic [31:0] words[16];

  mcbsp0_master_tx #(.CLK_DIV(2)) dut (
    .mcbsp_master_clk(clk), .mcbsp_master_rst(rst),
    .cfg_length(cfg_length), .cfg_gap(cfg_gap),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mcbsp_master_clkx(clkx), .mcbsp_master_fsx(fsx), .mcbsp_master_mosi(mosi),
    .tx_busy(tx_busy), .tx_word_done(tx_word_done), .debug_signal(debug_signal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model, sampling mid-bit on the clkx rising edge.
  initial begin
    logic pclkx, pfsx;
    pclkx = 1'b0; pfsx = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rx_cnt = 0;
      end else begin
        if (clkx && !pclkx) begin
          clkr_q.push_back(cyc);
          if (fsx) begin
            gap_q.push_back(idle_n);
            fs_mosi_q.push_back(mosi);
            idle_n = 0; fsx_hi_n++;
            rx_sh = {31'd0, mosi}; rx_cnt = 1;
          end else if (rx_cnt != 0) begin
            rx_sh = {rx_sh[30:0], mosi}; rx_cnt++;
          end else begin
            idle_n++;
          end
          if (rx_cnt != 0 && rx_cnt == rx_len) begin
            rx_q.push_back(rx_sh); rx_cnt = 0;
          end
        end
        if (fsx && !pfsx) fsx_q.push_back(cyc);
        if (tx_word_done) done_q.push_back(cyc);
      end
      pclkx = clkx; pfsx = fsx;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr();
    rx_q.delete(); gap_q.delete(); fsx_q.delete(); done_q.delete();
    clkr_q.delete(); fs_mosi_q.delete(); fsx_hi_n = 0;
  endtask

  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    @(negedge clk);
    tx_data = w; tx_valid = 1'b1;
    while (!tx_ready && n < 5000) begin @(negedge clk); n++; end
    send_wait = n;
    if (n >= 5000) chk("send_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input int cnt);
    int t;
    t = 0;
    while (rx_q.size() < cnt && t < 20000) begin @(negedge clk); t++; end
    if (rx_q.size() < cnt) chk("rx_timeout", 32'(rx_q.size()), 32'(cnt));
    repeat (20) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_clkx", 32'(clkx), 32'd0);
    chk("rst_fsx", 32'(fsx), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_done", 32'(tx_word_done), 32'd0);
    chk("rst_ready", 32'(tx_ready), 32'd1);

    // 1: single 32-bit word
    clr();
    send(32'hA5A5_0F0F);
    wait_rx(1);
    if (rx_q.size() >= 1) chk("t1_word", rx_q[0], 32'hA5A5_0F0F);
    chk("t1_fsx_bits", 32'(fsx_hi_n), 32'd1);
    if (fs_mosi_q.size() >= 1) chk("t1_fs_mosi", 32'(fs_mosi_q[0]), 32'd1);
    chk("t1_done_cnt", 32'(done_q.size()), 32'd1);
    if (done_q.size() >= 1 && fsx_q.size() >= 1)
      chk("t1_done_lat", 32'(done_q[0] - fsx_q[0]), 32'd128);
    if (clkr_q.size() >= 2)
      chk("t1_clkx_per", 32'(clkr_q[clkr_q.size()-1] - clkr_q[clkr_q.size()-2]), 32'd4);

    // 2: back-to-back, zero idle bits
    clr();
    send(32'h1234_5678);
    send(32'h8765_4321);
    chk("t2_ready_low", 32'(send_wait > 0), 32'd1);
    wait_rx(2);
    if (rx_q.size() >= 2) begin
      chk("t2_word0", rx_q[0], 32'h1234_5678);
      chk("t2_word1", rx_q[1], 32'h8765_4321);
    end
    if (gap_q.size() >= 2) chk("t2_idle", 32'(gap_q[1]), 32'd0);
    if (fsx_q.size() >= 2) chk("t2_fsx_sep", 32'(fsx_q[1] - fsx_q[0]), 32'd128);
    if (fsx_q.size() >= 2 && done_q.size() >= 1)
      chk("t2_done_eq_fsx", 32'(done_q[0]), 32'(fsx_q[1]));

    // 3: L=8, gap=3, second word queued
    clr();
    cfg_length = 7'd8; cfg_gap = 8'd3; rx_len = 8;
    send(32'h0000_00C3);
    send(32'h0000_005A);
    wait_rx(2);
    if (rx_q.size() >= 2) begin
      chk("t3_word0", rx_q[0], 32'h0000_00C3);
      chk("t3_word1", rx_q[1], 32'h0000_005A);
    end
    if (gap_q.size() >= 2) chk("t3_idle", 32'(gap_q[1]), 32'd3);
    if (fsx_q.size() >= 2) chk("t3_fsx_sep", 32'(fsx_q[1] - fsx_q[0]), 32'd44);

    // 4: out-of-range lengths behave as 32
    cfg_gap = 8'd0; rx_len = 32;
    clr();
    cfg_length = 7'd0;
    send(32'hFFFF_FFFE);
    wait_rx(1);
    if (rx_q.size() >= 1) chk("t4_len0_word", rx_q[0], 32'hFFFF_FFFE);
    if (done_q.size() >= 1 && fsx_q.size() >= 1)
      chk("t4_len0_lat", 32'(done_q[0] - fsx_q[0]), 32'd128);
    clr();
    cfg_length = 7'd40;
    send(32'hFFFF_FFFE);
    wait_rx(1);
    if (rx_q.size() >= 1) chk("t4_len40_word", rx_q[0], 32'hFFFF_FFFE);
    if (done_q.size() >= 1 && fsx_q.size() >= 1)
      chk("t4_len40_lat", 32'(done_q[0] - fsx_q[0]), 32'd128);

    // 5: reset at bit 10 with a word held
    clr();
    cfg_length = 7'd32;
    send(32'hDEAD_BEEF);
    send(32'hCAFE_F00D);
    begin
      int t;
      t = 0;
      while (rx_cnt != 10 && t < 2000) begin @(negedge clk); t++; end
      if (rx_cnt != 10) chk("t5_bit10_timeout", 32'(rx_cnt), 32'd10);
    end
    chk("t5_held", 32'(tx_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_clkx", 32'(clkx), 32'd0);
    chk("t5_fsx", 32'(fsx), 32'd0);
    chk("t5_mosi", 32'(mosi), 32'd0);
    chk("t5_ready", 32'(tx_ready), 32'd1);
    rst = 1'b0;
    clr();
    repeat (300) @(negedge clk);
    chk("t5_no_fsx", 32'(fsx_q.size()), 32'd0);
    send(32'h0BAD_F00D);
    wait_rx(1);
    if (rx_q.size() >= 1) chk("t5_after_word", rx_q[0], 32'h0BAD_F00D);

    // 6: loopback of 16 random words
    clr();
    for (int i = 0; i < 16; i++) words[i] = $urandom;
    for (int i = 0; i < 16; i++) send(words[i]);
    wait_rx(16);
    for (int i = 0; i < 16; i++)
      if (rx_q.size() > i) chk($sformatf("t6_word%0d", i), rx_q[i], words[i]);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
